uart_byte_tx: RTL and testbench

Serial byte transmitter that sits at the far end of the comm controller's tx_start/tx_byte/tx_ready handshake.
- Accepts one byte per request from the controller's write path.
- Drives it onto the UART TX line as 8N1 by default, with optional parity and a configurable number of stop bits.
- tx_ready tells the controller when the next byte may be requested.

---
 rtl/uart_byte_tx.sv | 154 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: edge-triggered request, byte captured on the falling
// request cycle, LSB-first frame with optional parity and 1 or 2 stop bits.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_tx_start_q;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_parity;
    logic             w_parity_nxt;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             w_bit_end;
    logic             w_rise;

    assign w_bit_end = (r_baud_cnt == CNT_LAST);
    assign w_rise    = tx_start & ~r_tx_start_q;

    assign tx_ready  = (r_state == S_IDLE);
    assign tx_done   = (r_state == S_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);
    assign uart_txd  = r_txd;

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!tx_start) begin
                    w_shift_nxt  = tx_byte;
                    w_parity_nxt = (^tx_byte) ^ (PARITY == 2);
                    w_baud_nxt   = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                // bit index doubles as the stop-bit counter here
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so uart_txd is a clean flop output
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
            S_PARITY: w_txd_nxt = w_parity_nxt;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_tx_start_q <= 1'b0;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_txd        <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_start_q <= tx_start;
            r_baud_cnt   <= w_baud_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_parity     <= w_parity_nxt;
            r_txd        <= w_txd_nxt;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances (8N1, 8E2, 8O2 at 4 clocks/bit)
// checked every cycle against a frame-level model plus directed literal checks.
module tb_uart_byte_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] tx_b  [3] = '{8'h00, 8'h00, 8'h00};
    logic       rdy   [3];
    logic       dn    [3];
    logic       txd   [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int dcnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .resetn(resetn), .tx_start(start[0]), .tx_byte(tx_b[0]),
        .tx_ready(rdy[0]), .tx_done(dn[0]), .uart_txd(txd[0]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .resetn(resetn), .tx_start(start[1]), .tx_byte(tx_b[1]),
        .tx_ready(rdy[1]), .tx_done(dn[1]), .uart_txd(txd[1]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .tx_start(start[2]), .tx_byte(tx_b[2]),
        .tx_ready(rdy[2]), .tx_done(dn[2]), .uart_txd(txd[2]));

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    function automatic int par_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
    endfunction

    function automatic int stop_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int nbits(input int d);
        return 9 + ((par_of(d) != 0) ? 1 : 0) + stop_of(d);
    endfunction

    function automatic logic [11:0] mk_frame(input int d, input logic [7:0] b);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par_of(d) != 0) f[9] = (^b) ^ (par_of(d) == 2);
        return f;
    endfunction

    int          m_mode  [3] = '{0, 0, 0};   // 0 idle, 1 armed, 2 sending
    int          m_k     [3] = '{0, 0, 0};   // 1-based cycle within the frame
    logic        m_q     [3] = '{1'b0, 1'b0, 1'b0};
    logic [11:0] m_frame [3] = '{12'hFFF, 12'hFFF, 12'hFFF};

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < 3; d++) begin
                m_mode[d] <= 0;
                m_k[d]    <= 0;
                m_q[d]    <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_q[d] <= start[d];
                case (m_mode[d])
                    0: if (start[d] && !m_q[d]) m_mode[d] <= 1;
                    1: if (!start[d]) begin
                        m_mode[d]  <= 2;
                        m_k[d]     <= 1;
                        m_frame[d] <= mk_frame(d, tx_b[d]);
                    end
                    default: begin
                        if (m_k[d] == CPB * nbits(d)) m_mode[d] <= 0;
                        else m_k[d] <= m_k[d] + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic et;
            logic er;
            logic ed;
            et = 1'b1;
            er = (m_mode[d] == 0);
            ed = 1'b0;
            if (m_mode[d] == 2) begin
                et = m_frame[d][(m_k[d] - 1) / CPB];
                ed = (m_k[d] == CPB * nbits(d));
            end
            chk1($sformatf("txd%0d", d), txd[d], et);
            chk1($sformatf("ready%0d", d), rdy[d], er);
            chk1($sformatf("done%0d", d), dn[d], ed);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++)
            if (resetn && dn[d] === 1'b1) dcnt[d] <= dcnt[d] + 1;
    end

    // ---------------- stimulus helpers (called at negedge+1) ----------------
    task automatic req(input int d, input logic [7:0] b, input int hi);
        start[d] = 1'b1;
        tx_b[d]  = ~b;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            if (i == 0) chk1($sformatf("rdy_low%0d", d), rdy[d], 1'b0);
            #1;
        end
        start[d] = 1'b0;
        tx_b[d]  = b;
        @(negedge clk);
        #1;
        tx_b[d]  = ~b;
    endtask

    task automatic sample_frame(input int d, input int n, output logic [11:0] bits);
        bits = '1;
        for (int j = 0; j < n; j++) begin
            repeat ((j == 0) ? 1 : CPB) @(negedge clk);
            bits[j] = txd[d];
        end
    endtask

    task automatic wait_ready(input int d, input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk1($sformatf("rdy_wait%0d", d), rdy[d], 1'b1);
    endtask

    logic [7:0] seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        logic [11:0] bits;
        int base;
        int t_prev;
        int t_now;

        // reset held with tx_start toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("rst_txd", txd[0], 1'b1);
            chk1("rst_rdy", rdy[0], 1'b1);
            chk1("rst_done", dn[0], 1'b0);
            #1;
            for (int d = 0; d < 3; d++) start[d] = ~start[d];
        end
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        @(negedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;

        // basic 8N1, 0xA5
        base = dcnt[0];
        req(0, 8'hA5, 2);
        sample_frame(0, 10, bits);
        chkv("frame_a5", 32'(bits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
        repeat (2) @(negedge clk);
        chk1("a5_done", dn[0], 1'b1);
        chk1("a5_rdy40", rdy[0], 1'b0);
        @(negedge clk);
        chk1("a5_rdy41", rdy[0], 1'b1);
        chkv("a5_done_cnt", 32'(dcnt[0] - base), 32'd1);
        #1;

        // even parity, two stop bits
        req(1, 8'h07, 2);
        sample_frame(1, 12, bits);
        chkv("frame_even", 32'(bits), 32'({2'b11, 1'b1, 8'h07, 1'b0}));
        chk1("par_even", bits[9], 1'b1);
        repeat (2) @(negedge clk);
        chk1("even_done", dn[1], 1'b1);
        chk1("even_rdy48", rdy[1], 1'b0);
        @(negedge clk);
        chk1("even_rdy49", rdy[1], 1'b1);
        #1;

        // odd parity, two stop bits
        req(2, 8'h07, 2);
        sample_frame(2, 12, bits);
        chkv("frame_odd", 32'(bits), 32'({2'b11, 1'b0, 8'h07, 1'b0}));
        chk1("par_odd", bits[9], 1'b0);
        repeat (2) @(negedge clk);
        chk1("odd_done", dn[2], 1'b1);
        @(negedge clk);
        chk1("odd_rdy49", rdy[2], 1'b1);
        #1;

        // controller-style back-to-back bytes
        base   = dcnt[0];
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready(0, 60);
            #1;
            req(0, seq[i], 1);
            t_now = cyc;
            if (i > 0) chkv("b2b_period", 32'(t_now - t_prev), 32'd42);
            t_prev = t_now;
            sample_frame(0, 10, bits);
            chkv("b2b_data", 32'(bits[8:1]), 32'(seq[i]));
            chk1("b2b_start", bits[0], 1'b0);
            chk1("b2b_stop", bits[9], 1'b1);
        end
        wait_ready(0, 60);
        chkv("b2b_done_cnt", 32'(dcnt[0] - base), 32'd4);
        #1;

        // request during DATA is ignored
        base = dcnt[0];
        req(0, 8'h3C, 1);
        repeat (8) @(negedge clk);
        #1;
        start[0] = 1'b1;
        tx_b[0]  = 8'hFF;
        @(negedge clk);
        chk1("ign_rdy", rdy[0], 1'b0);
        #1;
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk1("ign_bit3", txd[0], 1'b1);
        wait_ready(0, 60);
        repeat (20) @(negedge clk);
        chk1("ign_idle", txd[0], 1'b1);
        chkv("ign_done_cnt", 32'(dcnt[0] - base), 32'd1);
        #1;

        // reset during DATA bit 3
        base = dcnt[0];
        req(0, 8'h00, 1);
        repeat (17) @(negedge clk);
        chk1("mid_low", txd[0], 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        chk1("mid_txd", txd[0], 1'b1);
        chk1("mid_rdy", rdy[0], 1'b1);
        chk1("mid_done", dn[0], 1'b0);
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chkv("mid_no_done", 32'(dcnt[0] - base), 32'd0);
        #1;
        base = dcnt[0];
        req(0, 8'hFF, 1);
        sample_frame(0, 10, bits);
        chkv("frame_ff", 32'(bits[9:0]), 32'({1'b1, 8'hFF, 1'b0}));
        wait_ready(0, 60);
        chkv("ff_done_cnt", 32'(dcnt[0] - base), 32'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
